// File: rtl/register_file.sv
// Y86 decode-stage program register file: eight WIDTH-bit registers, two
// combinational read ports with write-back bypass, two write ports and a sticky illegal-code flag.
module register_file #(
    parameter int                WIDTH      = 32,
    parameter logic [WIDTH-1:0]  STACK_INIT = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dstE,
    input  logic [WIDTH-1:0] valE,
    input  logic [3:0]       dstM,
    input  logic [WIDTH-1:0] valM,
    input  logic             wb_stall,
    output logic             bad_reg
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [2:0] REG_ESP  = 3'd4;

    // Codes 0-7 address storage; F is "none"; 8-E are illegal.
    function automatic logic is_reg_code(input logic [3:0] code);
        return (code[3] == 1'b0);
    endfunction

    function automatic logic is_illegal_code(input logic [3:0] code);
        return (code[3] == 1'b1) && (code != REG_NONE);
    endfunction

    function automatic logic [WIDTH-1:0] reset_value(input logic [2:0] idx);
        logic [WIDTH-1:0] value;
        if (idx == REG_ESP) begin
            value = STACK_INIT;
        end else begin
            value = '0;
        end
        return value;
    endfunction

    // M is checked before E so a same-register double write reads back as valM.
    function automatic logic [WIDTH-1:0] select_operand(
        input logic [3:0]       src,
        input logic             bypass_en,
        input logic [3:0]       dst_m,
        input logic [WIDTH-1:0] val_m,
        input logic [3:0]       dst_e,
        input logic [WIDTH-1:0] val_e,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] result;
        if (!is_reg_code(src)) begin
            result = '0;
        end else if (bypass_en && (src == dst_m)) begin
            result = val_m;
        end else if (bypass_en && (src == dst_e)) begin
            result = val_e;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    logic [WIDTH-1:0] regs_r [0:7];
    logic             bad_reg_r;
    logic             we_e_s;
    logic             we_m_s;
    logic             bypass_en_s;
    logic             illegal_seen_s;
    logic [WIDTH-1:0] val_a_s;
    logic [WIDTH-1:0] val_b_s;

    // Write enables and bypass gating; reset also blocks the bypass so reads show reset contents.
    always_comb begin
        we_e_s         = (wb_stall == 1'b0) && is_reg_code(dstE);
        we_m_s         = (wb_stall == 1'b0) && is_reg_code(dstM);
        bypass_en_s    = (wb_stall == 1'b0) && (reset == 1'b0);
        illegal_seen_s = is_illegal_code(srcA) || is_illegal_code(srcB) ||
                         is_illegal_code(dstE) || is_illegal_code(dstM);
    end

    // Register array: M has priority over E when both target the same register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= reset_value(3'(i));
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (we_m_s && (dstM[2:0] == 3'(i))) begin
                    regs_r[i] <= valM;
                end else if (we_e_s && (dstE[2:0] == 3'(i))) begin
                    regs_r[i] <= valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Sticky illegal-code flag, independent of wb_stall, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_reg_r <= 1'b0;
        end else if (illegal_seen_s) begin
            bad_reg_r <= 1'b1;
        end else begin
            bad_reg_r <= bad_reg_r;
        end
    end

    // Combinational operand read with same-cycle bypass.
    always_comb begin
        val_a_s = select_operand(srcA, bypass_en_s, dstM, valM, dstE, valE, regs_r[srcA[2:0]]);
        val_b_s = select_operand(srcB, bypass_en_s, dstM, valM, dstE, valE, regs_r[srcB[2:0]]);
    end

    assign valA    = val_a_s;
    assign valB    = val_b_s;
    assign bad_reg = bad_reg_r;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a driver pushes expected operands computed
// from an array model of the eight registers; a negedge monitor pops and compares.
module tb_register_file;

    localparam logic [31:0] STACK_INIT = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  srcA = 4'hF, srcB = 4'hF, dstE = 4'hF, dstM = 4'hF;
    logic [31:0] valE = 32'h0, valM = 32'h0;
    logic        wb_stall = 1'b0;
    logic [31:0] valA, valB;
    logic        bad_reg;

    register_file #(.WIDTH(32), .STACK_INIT(STACK_INIT)) dut (
        .clk(clk), .reset(reset),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .wb_stall(wb_stall), .bad_reg(bad_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        bad;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          step_id = 0;

    // Reference model: architectural register contents and sticky flag.
    logic [31:0] model[8];
    logic        model_bad;

    // Inputs applied during the current cycle, committed at the next rising edge.
    logic        cur_rst = 1'b1, cur_stall = 1'b0;
    int          cur_dst_e = 15, cur_dst_m = 15;
    logic [31:0] cur_val_e = 32'h0, cur_val_m = 32'h0;
    int          cur_src_a = 15, cur_src_b = 15;

    function automatic logic illegal(input int code);
        return (code >= 8) && (code <= 14);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = (i == 4) ? STACK_INIT : 32'h0;
        model_bad = 1'b0;
    endtask

    // Newest value the execute stage should see: contents after this cycle's writes (M written last).
    function automatic logic [31:0] model_read(input int src);
        logic [31:0] nxt[8];
        for (int i = 0; i < 8; i++) nxt[i] = model[i];
        if (!cur_rst && !cur_stall) begin
            if (cur_dst_e < 8) nxt[cur_dst_e] = cur_val_e;
            if (cur_dst_m < 8) nxt[cur_dst_m] = cur_val_m;
        end
        return (src < 8) ? nxt[src] : 32'h0;
    endfunction

    task automatic model_commit();
        if (!cur_rst) begin
            if (!cur_stall) begin
                if (cur_dst_e < 8) model[cur_dst_e] = cur_val_e;
                if (cur_dst_m < 8) model[cur_dst_m] = cur_val_m;
            end
            if (illegal(cur_src_a) || illegal(cur_src_b) || illegal(cur_dst_e) || illegal(cur_dst_m))
                model_bad = 1'b1;
        end
    endtask

    // One cycle: commit the previous cycle at the edge, then drive new inputs mid-cycle.
    task automatic step(input logic rst, input logic stall, input int sa, input int sb,
                        input int de, input logic [31:0] ve, input int dm, input logic [31:0] vm);
        exp_t e;
        @(posedge clk);
        model_commit();
        #1;
        reset = rst; wb_stall = stall;
        srcA = 4'(sa); srcB = 4'(sb); dstE = 4'(de); valE = ve; dstM = 4'(dm); valM = vm;
        cur_rst = rst; cur_stall = stall; cur_src_a = sa; cur_src_b = sb;
        cur_dst_e = de; cur_val_e = ve; cur_dst_m = dm; cur_val_m = vm;
        if (rst) model_reset();
        e.id = step_id; e.a = model_read(sa); e.b = model_read(sb); e.bad = model_bad;
        exp_q.push_back(e);
        step_id++;
    endtask

    function automatic int rand_code();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return int'($urandom_range(8, 14));
        if (r == 1) return 15;
        return int'($urandom_range(0, 7));
    endfunction

    // Monitor: outputs are combinational, so each cycle presents one result at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (valA !== e.a) begin
                errors++;
                $display("FAIL valA step %0d: got %h expected %h", e.id, valA, e.a);
            end
            checks++;
            if (valB !== e.b) begin
                errors++;
                $display("FAIL valB step %0d: got %h expected %h", e.id, valB, e.b);
            end
            checks++;
            if (bad_reg !== e.bad) begin
                errors++;
                $display("FAIL bad_reg step %0d: got %b expected %b", e.id, bad_reg, e.bad);
            end
        end
    end

    initial begin
        model_reset();
        // Reads while reset is held, then after release.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i, 7 - i, 15, 32'h0, 15, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, i, 7 - i, 15, 32'h0, 15, 32'h0);
        // Write E and same-cycle bypass, then array read.
        step(1'b0, 1'b0, 0, 3, 3, 32'hDEAD_BEEF, 15, 32'h0);
        step(1'b0, 1'b0, 3, 3, 15, 32'h0, 15, 32'h0);
        // Write conflict on %esp: M wins.
        step(1'b0, 1'b0, 4, 0, 4, 32'h1111_1111, 4, 32'h2222_2222);
        step(1'b0, 1'b0, 4, 4, 15, 32'h0, 15, 32'h0);
        // Stall suppresses write and bypass.
        step(1'b0, 1'b1, 1, 1, 1, 32'h5, 15, 32'h0);
        step(1'b0, 1'b0, 1, 1, 15, 32'h0, 15, 32'h0);
        // Illegal codes: zero read, sticky flag, no write.
        step(1'b0, 1'b0, 0, 9, 15, 32'h0, 15, 32'h0);
        step(1'b0, 1'b0, 2, 0, 10, 32'hFFFF_FFFF, 15, 32'h0);
        step(1'b0, 1'b0, 2, 3, 15, 32'h0, 15, 32'h0);
        step(1'b0, 1'b1, 4, 5, 15, 32'h0, 15, 32'h0);
        // Asynchronous reset mid-cycle and a lost write under reset.
        step(1'b0, 1'b0, 0, 0, 2, 32'h77, 15, 32'h0);
        step(1'b0, 1'b0, 2, 2, 15, 32'h0, 15, 32'h0);
        step(1'b1, 1'b0, 2, 4, 15, 32'h0, 15, 32'h0);
        step(1'b1, 1'b0, 2, 2, 2, 32'h99, 15, 32'h0);
        step(1'b0, 1'b0, 2, 4, 15, 32'h0, 15, 32'h0);
        // Randomized traffic with occasional stalls, illegal codes and resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 rand_code(), rand_code(), rand_code(), $urandom(), rand_code(), $urandom());
        end
        step(1'b0, 1'b0, 15, 15, 15, 32'h0, 15, 32'h0);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
